// File: rtl/move_gen_ctrl.sv
// Sequences one move-generation query through the square mesh and returns the filtered move mask.
// Define PAWN_DOUBLE_PUSH_EN to add the two-square pawn advance from the home rank.
module move_gen_ctrl #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_square,
    input  logic [3:0]  req_piece,
    input  logic [63:0] req_occupied,
    input  logic [63:0] req_white,
    output logic        mesh_init,
    output logic [63:0] mesh_occupied,
    output logic [63:0] mesh_color,
    output logic [5:0]  mesh_square_calc,
    output logic [3:0]  mesh_piece_calc,
    input  logic [63:0] mesh_movebits,
    output logic        moves_valid,
    input  logic        moves_ready,
    output logic [63:0] moves,
    output logic [6:0]  move_count
);
    // state   | meaning
    // IDLE    | ready for a request
    // INIT    | mesh_init pulse, mesh loads occupancy
    // SETTLE  | counting down while the mesh ripples
    // CAPTURE | sample and filter movebits
    // OUT     | result held until consumer takes it
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    localparam logic [5:0] SETTLE_INIT = 6'(SETTLE_CYCLES - 1);
    localparam logic [3:0] P_BPAWN = 4'd5;
    localparam logic [3:0] P_WPAWN = 4'd11;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  sq_q, sq_d;
    logic [3:0]  piece_q, piece_d;
    logic [63:0] occ_q, occ_d;
    logic [63:0] white_q, white_d;
    logic [63:0] moves_q, moves_d;
    logic [6:0]  count_q, count_d;
    logic        req_ready_q, req_ready_d;
    logic        mesh_init_q, mesh_init_d;
    logic        moves_valid_q, moves_valid_d;

    logic [63:0] pawn_mask, dbl_mask, filt;
    logic [6:0]  filt_cnt;
    logic [2:0]  sq_file, sq_rank;
    logic        is_wp, is_bp;

    assign sq_file = sq_q[2:0];
    assign sq_rank = sq_q[5:3];
    assign is_wp   = (piece_q == P_WPAWN);
    assign is_bp   = (piece_q == P_BPAWN);

    // Pawn targets are rebuilt from occupancy; mesh bits only survive where a pawn rule allows them.
    always_comb begin
        pawn_mask = '0;
        dbl_mask  = '0;
        if (is_wp && sq_rank != 3'd7) begin
            if (!occ_q[sq_q + 6'd8]) pawn_mask[sq_q + 6'd8] = 1'b1;
            if (sq_file != 3'd0 && occ_q[sq_q + 6'd7] && !white_q[sq_q + 6'd7])
                pawn_mask[sq_q + 6'd7] = 1'b1;
            if (sq_file != 3'd7 && occ_q[sq_q + 6'd9] && !white_q[sq_q + 6'd9])
                pawn_mask[sq_q + 6'd9] = 1'b1;
        end
        if (is_bp && sq_rank != 3'd0) begin
            if (!occ_q[sq_q - 6'd8]) pawn_mask[sq_q - 6'd8] = 1'b1;
            if (sq_file != 3'd7 && occ_q[sq_q - 6'd7] && white_q[sq_q - 6'd7])
                pawn_mask[sq_q - 6'd7] = 1'b1;
            if (sq_file != 3'd0 && occ_q[sq_q - 6'd9] && white_q[sq_q - 6'd9])
                pawn_mask[sq_q - 6'd9] = 1'b1;
        end
`ifdef PAWN_DOUBLE_PUSH_EN
        if (is_wp && sq_rank == 3'd1 && !occ_q[sq_q + 6'd8] && !occ_q[sq_q + 6'd16])
            dbl_mask[sq_q + 6'd16] = 1'b1;
        if (is_bp && sq_rank == 3'd6 && !occ_q[sq_q - 6'd8] && !occ_q[sq_q - 6'd16])
            dbl_mask[sq_q - 6'd16] = 1'b1;
`endif
        if (is_wp || is_bp) filt = (mesh_movebits & pawn_mask) | dbl_mask;
        else                filt = mesh_movebits;
        filt[sq_q] = 1'b0;
        if (piece_q >= 4'd12) filt = '0;
        filt_cnt = '0;
        for (int i = 0; i < 64; i++) filt_cnt = filt_cnt + {6'd0, filt[i]};
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sq_d          = sq_q;
        piece_d       = piece_q;
        occ_d         = occ_q;
        white_d       = white_q;
        moves_d       = moves_q;
        count_d       = count_q;
        req_ready_d   = req_ready_q;
        mesh_init_d   = 1'b0;
        moves_valid_d = moves_valid_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                sq_d        = req_square;
                piece_d     = req_piece;
                occ_d       = req_occupied;
                white_d     = req_white;
                req_ready_d = 1'b0;
                mesh_init_d = 1'b1;
                state_d     = S_INIT;
            end
            S_INIT: begin
                cnt_d   = SETTLE_INIT;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 6'd0) state_d = S_CAPTURE;
                else               cnt_d   = cnt_q - 6'd1;
            end
            S_CAPTURE: begin
                moves_d       = filt;
                count_d       = filt_cnt;
                moves_valid_d = 1'b1;
                state_d       = S_OUT;
            end
            S_OUT: if (moves_ready) begin
                moves_valid_d = 1'b0;
                req_ready_d   = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d       = S_IDLE;
                req_ready_d   = 1'b1;
                moves_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sq_q          <= '0;
            piece_q       <= '0;
            occ_q         <= '0;
            white_q       <= '0;
            moves_q       <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b1;
            mesh_init_q   <= 1'b0;
            moves_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sq_q          <= sq_d;
            piece_q       <= piece_d;
            occ_q         <= occ_d;
            white_q       <= white_d;
            moves_q       <= moves_d;
            count_q       <= count_d;
            req_ready_q   <= req_ready_d;
            mesh_init_q   <= mesh_init_d;
            moves_valid_q <= moves_valid_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign mesh_init        = mesh_init_q;
    assign mesh_occupied    = occ_q;
    assign mesh_color       = white_q;
    assign mesh_square_calc = sq_q;
    assign mesh_piece_calc  = piece_q;
    assign moves_valid      = moves_valid_q;
    assign moves            = moves_q;
    assign move_count       = count_q;
endmodule

// File: doc/move_gen_ctrl.md
# move_gen_ctrl

Sequencer that drives the 64-square move-generation mesh from the software side and collects its answer. It accepts a board snapshot plus the square and piece to evaluate, and pulses the mesh `init` to load occupancy. It then waits for the combinational ripple to settle and captures the 64 `movebit` outputs. Before returning a 64-bit move mask and popcount over a valid/ready handshake, it applies the pawn rules the mesh cannot express.

## Interface
Parameters:
- SETTLE_CYCLES, 8: cycles allowed for mesh propagation after init; legal range 1..63.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted when req_valid & req_ready
- req_square  in  6  square to evaluate, index = rank*8+file, rank 0 = white home rank
- req_piece  in  4  piece code: BROOK 0, BBISHOP 1, BKNIGHT 2, BQUEEN 3, BKING 4, BPAWN 5, WROOK 6, WBISHOP 7, WKNIGHT 8, WQUEEN 9, WKING 10, WPAWN 11
- req_occupied  in  64  bit n = square n occupied
- req_white  in  64  bit n = piece on square n is white (don't-care if empty)
- mesh_init  out  1  init to every square
- mesh_occupied  out  64  per-square occupied
- mesh_color  out  64  per-square occupying_piece_color
- mesh_square_calc  out  6  to every square
- mesh_piece_calc  out  4  to every square
- mesh_movebits  in  64  movebit from square n
- moves_valid  out  1  result present
- moves_ready  in  1  consumer accepts result
- moves  out  64  legal-target mask
- move_count  out  7  popcount of moves, 0..64

## Operation
- States: IDLE, INIT, SETTLE, CAPTURE, OUT.
- IDLE: req_ready=1. On acceptance, latch all req_* into registers and go to INIT.
- INIT: mesh_init=1 for exactly one cycle, then go to SETTLE with the counter = SETTLE_CYCLES-1.
- SETTLE: decrement each cycle. Go to CAPTURE when the counter = 0.
- CAPTURE: sample mesh_movebits, filter, register moves and move_count, then go to OUT.
- OUT: moves_valid=1. Hold moves and move_count stable until moves_valid & moves_ready, then return to IDLE.
- mesh_occupied, mesh_color, mesh_square_calc and mesh_piece_calc are driven from the latched registers. They stay constant from INIT through OUT and are unchanged in IDLE.
- Filter, always applied:
  - The bit at the evaluated square is cleared.
  - Piece code 12..15 gives moves=0, move_count=0, and the transaction still completes.
- Pawn filter (BPAWN/WPAWN), always applied:
  - Forward target (sq+8 for white, sq-8 for black) is kept only if it is empty.
  - Diagonal targets (±7/±9 in the forward direction, with file difference exactly 1) are kept only if occupied by the opposite colour.
  - All other bits are cleared.
  - An off-board forward target yields no bit.
- req_valid is ignored outside IDLE. Request inputs are not sampled mid-transaction.
- Reset values: state IDLE, req_ready=1, mesh_init=0, moves_valid=0, moves=0, move_count=0, all latched request registers 0.
- Reset asserted in any state aborts immediately with no partial result. The first request after deassertion is handled normally.

## Timing
- Acceptance edge E0. mesh_init is high for the cycle after E0.
- moves_valid rises SETTLE_CYCLES+2 edges after E0, which is 10 cycles with the default.
- If moves_ready is high when moves_valid rises, the handshake completes at that edge. req_ready is 1 on the following cycle.
- Back-to-back throughput is one request per SETTLE_CYCLES+4 cycles, with req_valid held and moves_ready tied high.
- All outputs are registered. None depends combinationally on req_valid or moves_ready.

## Configuration
- PAWN_DOUBLE_PUSH_EN defined: double push is enabled. The double-push target is set when:
  - WPAWN on sq 8..15 with sq+8 and sq+16 both empty sets bit sq+16.
  - BPAWN on sq 48..55 with sq-8 and sq-16 both empty sets bit sq-16.
  - move_count includes these bits.
- PAWN_DOUBLE_PUSH_EN undefined: the double-push logic is absent. Pawns get single-step and capture targets only.

## Test plan
Benches use a behavioural mesh model.
- Reset: hold reset_n low for 3 cycles, then release. Required: req_ready=1, moves_valid=0, moves=0, move_count=0, mesh_init=0.
- White rook alone on sq 0: moves=0x01010101010101FE and move_count=14. moves_valid rises exactly 10 edges after acceptance with SETTLE_CYCLES=8.
- WPAWN alone on sq 12, macro defined: moves=0x0000000010100000, count 2. Macro undefined: 0x0000000000100000, count 1.
- BPAWN on sq 51, white piece on sq 42, any piece on sq 43, sq 44 empty: moves=0x0000040000000000, count 1. The blocked forward square also blocks the double push.
- Backpressure: hold moves_ready=0 for 5 cycles in OUT while pulsing req_valid with a new request. Required: moves is stable, req_ready=0, and the new request is not latched. The result completes when moves_ready=1.
- Assert reset_n low during SETTLE. Required:
  - All outputs return to reset values at once.
  - moves_valid never asserts for the aborted request.
  - The next request produces a correct result.
